// File: rtl/port_xor_lookup_pkg.sv
// Shared definitions for the output-port lookup stage: IOQ header field
// positions, the IOQ header ctrl marker, FSM encodings and the dst helper.
package port_xor_lookup_pkg;

    localparam int BYTE_LEN_POS = 0;
    localparam int SRC_PORT_POS = 16;
    localparam int WORD_LEN_POS = 32;
    localparam int DST_PORT_POS = 48;
    localparam int FIELD_W      = 16;

    localparam logic [7:0] IOQ_CTRL = 8'hFF;

    typedef enum logic {
        HDRS    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // One-hot destination for a source port; zero when the source is not
    // a real port so that downstream drops the packet.
    function automatic logic [FIELD_W-1:0] dst_for_src(
        input logic [FIELD_W-1:0] src,
        input int                 num_ports,
        input int                 port_xor
    );
        logic [FIELD_W-1:0] dst;
        dst = '0;
        if (int'(src) < num_ports)
            dst = FIELD_W'(1) << (src ^ FIELD_W'(port_xor));
        return dst;
    endfunction

endpackage

// File: rtl/port_xor_lookup_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is always on dout.
// Ports: clk, reset (sync, active-high), din/wr_en, dout/rd_en,
// nearly_full (one slot left), empty.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = depth == (MAX_DEPTH_BITS+1)'(DEPTH);
    assign nearly_full = depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1);
    assign empty       = depth == '0;
    assign dout        = mem[rd_ptr];

    // A read on a full FIFO frees the slot the write lands in.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/port_xor_lookup.sv
// Output-port lookup: buffers the arbiter stream, rewrites the one-hot dst
// of IOQ headers from src ^ PORT_XOR, counts packets and bad sources.
// Ports: clk, reset (sync, active-high); in_data/in_ctrl/in_wr/in_rdy
// upstream; out_data/out_ctrl/out_wr/out_rdy downstream (registered);
// pkt_count, bad_src_count to the register block.
module port_xor_lookup #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int                    NUM_PORTS  = 8,
    parameter int                    PORT_XOR   = 2,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL   =
        CTRL_WIDTH'(port_xor_lookup_pkg::IOQ_CTRL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkt_count,
    output logic [31:0]           bad_src_count
);

    import port_xor_lookup_pkg::*;

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]            head_data;
    logic [CTRL_WIDTH-1:0]            head_ctrl;
    logic                             nearly_full;
    logic                             empty;
    logic                             rd_en;
    logic [FIELD_W-1:0]               src;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  pkt_inc;
    logic                  bad_inc;
    logic [31:0]           pkt_cnt;
    logic [31:0]           bad_cnt;

    // Writes while nearly full are dropped; upstream is expected to
    // honour in_rdy so this never loses a word in practice.
    small_fifo #(
        .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr & ~nearly_full),
        .rd_en       (rd_en),
        .dout        (head),
        .nearly_full (nearly_full),
        .empty       (empty)
    );

    assign {head_ctrl, head_data} = head;
    assign in_rdy    = ~nearly_full;
    assign rd_en     = out_rdy & ~empty;
    assign src       = head_data[SRC_PORT_POS +: FIELD_W];

    always_comb begin
        state_next = state;
        data_next  = head_data;
        pkt_inc    = 1'b0;
        bad_inc    = 1'b0;
        unique case (state)
            HDRS: begin
                if (head_ctrl == IOQ_CTRL) begin
                    data_next[DST_PORT_POS +: FIELD_W] =
                        dst_for_src(src, NUM_PORTS, PORT_XOR);
                    bad_inc = rd_en & (int'(src) >= NUM_PORTS);
                end else if (head_ctrl == '0 && rd_en) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // First non-zero ctrl after data is the last word.
                if (head_ctrl != '0 && rd_en) begin
                    pkt_inc    = 1'b1;
                    state_next = HDRS;
                end
            end
            default: state_next = HDRS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HDRS;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
            pkt_cnt  <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_next;
            out_wr   <= rd_en;
            out_data <= data_next;
            out_ctrl <= head_ctrl;
            pkt_cnt  <= pkt_cnt + 32'(pkt_inc);
            bad_cnt  <= bad_cnt + 32'(bad_inc);
        end
    end

    assign pkt_count     = pkt_cnt;
    assign bad_src_count = bad_cnt;

endmodule
